// File: rtl/edge_pkg.sv
// Shared definitions for the edge-detection datapath FIFOs and line buffers.
package edge_pkg;

  // Read-side behaviour of stream_fifo and the line buffers
  localparam int FIFO_MODE_STROBE = 0;  // registered read, 1-cycle latency
  localparam int FIFO_MODE_FWFT   = 1;  // head word presented without a request

  // Level indicators derived from the fill count
  typedef struct packed {
    logic full;
    logic empty;
    logic almostfull;
    logic almostempty;
  } fifo_status_t;

  // Sticky error flags
  typedef struct packed {
    logic overflow;
    logic underflow;
  } fifo_flags_t;

  // Level indicators as a pure function of the fill count and thresholds
  function automatic fifo_status_t calc_status(input int unsigned fill,
                                               input int unsigned depth,
                                               input int unsigned af_lvl,
                                               input int unsigned ae_lvl);
    fifo_status_t s;
    s.full        = (fill == depth);
    s.empty       = (fill == 0);
    s.almostfull  = (fill >= depth - af_lvl);
    s.almostempty = (fill <= ae_lvl);
    return s;
  endfunction

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port, one synchronous read port.
// The read register doubles as the FIFO output stage, so it is resettable.
module sdp_ram #(
  parameter int DW   = 8,
  parameter int ADDR = 9
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            wr_en,
  input  logic [ADDR-1:0] wr_addr,
  input  logic [DW-1:0]   wr_data,
  input  logic            rd_en,
  input  logic [ADDR-1:0] rd_addr,
  output logic [DW-1:0]   rd_data
);

  logic [DW-1:0] mem [2**ADDR];

  // Storage array, no reset
  always_ff @(posedge CLK) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Registered read; holds its value when no read is issued
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)       rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/stream_fifo.sv
// Valid/ready stream FIFO with STROBE or FWFT read side, sticky error flags
// and synchronous flush. o_fill counts every word accepted and not yet popped,
// including the word sitting in the output register in FWFT mode.
module stream_fifo
  import edge_pkg::*;
#(
  parameter int DW     = 8,
  parameter int ADDR   = 9,
  parameter int MODE   = FIFO_MODE_FWFT,
  parameter int AF_LVL = 2,
  parameter int AE_LVL = 2
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            i_flush,
  input  logic            i_wr_valid,
  output logic            o_wr_ready,
  input  logic [DW-1:0]   i_wr_data,
  input  logic            i_rd_ready,
  output logic            o_rd_valid,
  output logic [DW-1:0]   o_rd_data,
  output logic [ADDR:0]   o_fill,
  output logic            o_full,
  output logic            o_empty,
  output logic            o_almostfull,
  output logic            o_almostempty,
  output logic            o_overflow,
  output logic            o_underflow
);

  localparam int          DEPTH   = 2**ADDR;
  localparam logic [ADDR:0] DEPTH_C = (ADDR+1)'(DEPTH);
  localparam bit          FWFT    = (MODE == FIFO_MODE_FWFT);

  logic [ADDR-1:0] wp, rp;
  logic [ADDR:0]   fill;
  logic [ADDR:0]   ram_cnt;   // words still in RAM (not in the output register)
  logic            head_vld;  // FWFT: output register holds the head; STROBE: read pulse
  fifo_flags_t     flags;
  fifo_status_t    stat;
  logic            wr_acc, pop, ram_rd;

  // Level indicators straight from the fill count
  always_comb begin
    stat = calc_status(32'(fill), 32'(DEPTH), 32'(AF_LVL), 32'(AE_LVL));
  end

  // Handshake decode; flush suppresses every transfer in its cycle
  always_comb begin
    wr_acc  = i_wr_valid & (fill != DEPTH_C) & !i_flush;
    pop     = 1'b0;
    ram_cnt = fill;
    ram_rd  = 1'b0;
    if (FWFT) begin
      pop     = head_vld & i_rd_ready & !i_flush;
      ram_cnt = fill - {{ADDR{1'b0}}, head_vld};
      // prefetch whenever the output register is free or being vacated
      ram_rd  = !i_flush & (ram_cnt != '0) & (!head_vld | pop);
    end else begin
      pop     = i_rd_ready & (fill != '0) & !i_flush;
      ram_rd  = pop;
    end
  end

  // Write/read pointers wrap naturally at DEPTH
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wp <= '0;
      rp <= '0;
    end else if (i_flush) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (wr_acc) wp <= wp + 1'b1;
      if (ram_rd) rp <= rp + 1'b1;
    end
  end

  // Fill counter: write and pop in the same cycle cancel out
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)         fill <= '0;
    else if (i_flush) fill <= '0;
    else begin
      case ({wr_acc, pop})
        2'b10:   fill <= fill + 1'b1;
        2'b01:   fill <= fill - 1'b1;
        default: fill <= fill;
      endcase
    end
  end

  // Output-register valid: FWFT holds until popped, STROBE pulses per read
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) head_vld <= 1'b0;
    else if (FWFT) begin
      if (i_flush)     head_vld <= 1'b0;
      else if (ram_rd) head_vld <= 1'b1;
      else if (pop)    head_vld <= 1'b0;
    end else begin
      head_vld <= ram_rd;
    end
  end

  // Sticky error flags; underflow only exists for explicit STROBE requests
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)         flags <= '0;
    else if (i_flush) flags <= '0;
    else begin
      if (i_wr_valid & stat.full)                 flags.overflow  <= 1'b1;
      if (!FWFT & i_rd_ready & stat.empty)        flags.underflow <= 1'b1;
    end
  end

  sdp_ram #(.DW(DW), .ADDR(ADDR)) u_ram (
    .CLK     (CLK),
    .RST     (RST),
    .wr_en   (wr_acc),
    .wr_addr (wp),
    .wr_data (i_wr_data),
    .rd_en   (ram_rd),
    .rd_addr (rp),
    .rd_data (o_rd_data)
  );

  assign o_wr_ready    = !stat.full;
  assign o_rd_valid    = head_vld;
  assign o_fill        = fill;
  assign o_full        = stat.full;
  assign o_empty       = stat.empty;
  assign o_almostfull  = stat.almostfull;
  assign o_almostempty = stat.almostempty;
  assign o_overflow    = flags.overflow;
  assign o_underflow   = flags.underflow;

endmodule
